// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// State encoding plus bit-counter width derivation.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the only arithmetic in the serial adder.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b mode).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import serial_adder_pkg::*;

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New bit enters at the MSB; after WIDTH shifts it is aligned.
  assign res_next = {fa_sum, res_sr};

  // Subtract is a + ~b + 1 through the same adder cell.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= fa_cout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            sum   <= res_next;
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Arithmetic reference model plus directed literal checks.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int done_cnt = 0;
  bit check_en = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;
  always @(negedge clk) if (done) done_cnt++;

  logic sub_m;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_m = sub;
`else
  assign sub_m = 1'b0;
`endif

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] calc(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic c,
    input logic s
  );
    logic [W-1:0] yy;
    logic cc;
    int u;
    int sv;
    int maxv;
    int minv;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    u = int'(x) + int'(yy) + int'(cc);
    sv = int'($signed(x)) + int'($signed(yy)) + int'(cc);
    maxv = (1 << (W - 1)) - 1;
    minv = -(1 << (W - 1));
    return {(sv > maxv) || (sv < minv), u[W], u[W-1:0]};
  endfunction

  // Model: idle until start, then W edges later publish the result.
  int           left = 0;
  logic [W+1:0] pend = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left   <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (left > 0) begin
        left <= left - 1;
        if (left == 1) begin
          m_sum  <= pend[W-1:0];
          m_cout <= pend[W];
          m_ovf  <= pend[W+1];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (start) begin
        pend   <= calc(a, b, cin, sub_m);
        left   <= W;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if ({busy, done, cout, ovf, sum} !==
          {m_busy, m_done, m_cout, m_ovf, m_sum}) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, need busy=%b done=%b sum=%h cout=%b ovf=%b",
                 cycle, busy, done, sum, cout, ovf,
                 m_busy, m_done, m_sum, m_cout, m_ovf);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic c
  );
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    tick();
  endtask

  task automatic op(
    input string nm,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic c,
    input logic [W-1:0] es,
    input logic ec,
    input logic eo
  );
    int lat;
    issue(x, y, c);
    wait_done(lat);
    chk({nm, " latency"}, lat, W);
    chk({nm, " sum"}, int'(sum), int'(es));
    chk({nm, " cout"}, int'(cout), int'(ec));
    chk({nm, " ovf"}, int'(ovf), int'(eo));
  endtask

  initial begin
    int lat;
    int d0;
    int cyc[3];
    int n;
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    logic [W-1:0] bb_s[3];

    #1 rst_n = 1'b0;
    check_en = 1'b1;
    tick();
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset sum", int'(sum), 0);
    chk("reset cout", int'(cout), 0);
    chk("reset ovf", int'(ovf), 0);
    rst_n = 1'b1;
    tick();

    op("add 35+4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    op("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op("add 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op("add 80+80", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

    // start during RUN must be ignored
    d0 = done_cnt;
    issue(8'h12, 8'h34, 1'b1);
    tick();
    tick();
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("ignore latency", lat, W - 3);
    chk("ignore sum", int'(sum), 'h47);
    repeat (4) tick();
    chk("ignore single done", done_cnt - d0, 1);

    // reset in the middle of RUN
    issue(8'h55, 8'h22, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst sum", int'(sum), 0);
    chk("midrst done", int'(done), 0);
    d0 = done_cnt;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midrst no done", done_cnt - d0, 0);
    op("after rst", 8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);

    // start held high: back-to-back operations
    bb_a = '{8'h01, 8'h10, 8'h40};
    bb_b = '{8'h02, 8'h20, 8'h41};
    bb_s = '{8'h03, 8'h30, 8'h81};
    a = bb_a[0];
    b = bb_b[0];
    cin = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 30);
      chk("b2b done seen", int'(done), 1);
      cyc[k] = cycle;
      chk("b2b sum", int'(sum), int'(bb_s[k]));
      if (k < 2) begin
        a = bb_a[k+1];
        b = bb_b[k+1];
        repeat (4) @(negedge clk);
        chk("b2b hold", int'(sum), int'(bb_s[k]));
      end else begin
        start = 1'b0;
      end
    end
    chk("b2b spacing 1", cyc[1] - cyc[0], W + 1);
    chk("b2b spacing 2", cyc[2] - cyc[1], W + 1);
    chk("b2b ovf", int'(ovf), 1);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    op("sub 10-01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0);
    op("sub 00-01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    op("sub 80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    sub = 1'b0;
`endif

    // random traffic, including start noise and rare resets
    repeat (3000) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit `full_adder` cell over a WIDTH-bit operand pair, one bit per clock, LSB first. Sits beside the ripple/parallel adder datapaths as the area-minimal alternative for slow-path arithmetic. Accepts a start request, runs WIDTH cycles, then presents a registered sum, carry-out and signed-overflow flag with a one-cycle done pulse.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled on a clk edge in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- sub  input  1  present only with SERIAL_ADDER_SUB_EN; 1 = compute a - b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into MSB XOR cout.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE with start=1: load shift regs A<=a, B<=b, carry FF<=cin, bit counter<=0; go RUN.
- DONE with start=0: go IDLE. IDLE with start=0: stay.
- RUN, every edge: full_adder(A[0], B[0], carry) -> sum bit shifted into MSB of result shift reg; carry FF<=cout; A, B shift right one; counter+1. Before updating carry on the counter=WIDTH-1 edge, capture carry FF as carry-into-MSB.
- RUN, on the edge where counter=WIDTH-1: load sum, cout, ovf output registers from the shift reg/carry; go DONE.
- start while in RUN ignored; operand inputs ignored outside the accepting edge.
- Arithmetic: modulo 2^WIDTH; cout is unsigned carry, ovf is two's-complement overflow.
- Output registers change only on completion; sum/cout/ovf stable throughout RUN.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; internal regs 0.
- Reset assertion mid-RUN: immediate return to IDLE, outputs to reset values; no done pulse.
- Latency: accepting edge E0; RUN edges E1..E(WIDTH); done=1 and result valid after E(WIDTH) for exactly one cycle.
- busy high from after E0 until after E(WIDTH).
- Back-to-back: start=1 while done=1 is accepted; next result after another WIDTH edges; throughput one op per WIDTH+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub port exists; when sub=1 at acceptance, B<=~b and carry FF<=1 (cin ignored); cout=1 means no borrow.
- Not defined: no sub port; add only, cin used as given.

## Structure
- Package serial_adder_pkg: state enum typedef (IDLE, RUN, DONE), CNT_W = $clog2(WIDTH) helper constant.
- One sub-module: full_adder (a, b, cin -> sum, cout), instantiated once; all sequencing, shifting and flags in this block.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, cin=0, start one cycle -> done exactly 8 edges after acceptance edge; sum=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- start pulsed again at RUN cycle 3 with different operands -> ignored; result matches first operands; single done pulse.
- rst_n low at RUN cycle 4 -> busy=0, sum=0, no done; new start afterwards completes normally.
- start held high across done -> back-to-back ops, done pulses spaced 9 cycles apart; sum between pulses holds prior value.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x00, b=0x01 -> sum=0xFF, cout=0.
